// File: rtl/bsg_clk_div_lanes.sv
// Programmable clock divider driving a bus of per-lane gated divided clocks.
// All ratio and enable changes are applied only at a divided-clock rising
// boundary, so every lane pulse is always a full-width high phase.
module bsg_clk_div_lanes #(
  parameter int width_p     = 128,
  parameter int div_width_p = 8,
  parameter int init_div_p  = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   div_v_i,
  input  logic [div_width_p-1:0] div_i,
  output logic                   div_ready_o,
  input  logic [width_p-1:0]     en_i,
  output logic [width_p-1:0]     o,
  output logic                   tick_o
);

  localparam logic [div_width_p-1:0] init_div_lp = div_width_p'(init_div_p);

  logic [div_width_p-1:0] div_reg, div_next;
  logic [div_width_p-1:0] cnt_reg, cnt_next;
  logic                   phase_reg, phase_next;
  logic                   pend_v_reg, pend_v_next;
  logic [div_width_p-1:0] pend_reg, pend_next;
  logic [width_p-1:0]     en_reg, en_next;
  logic [width_p-1:0]     o_reg, o_next;
  logic                   tick_reg, tick_next;

  logic at_end;
  logic rise_b;
  logic accept;

  assign at_end = (cnt_reg == div_reg);
  assign rise_b = at_end && !phase_reg;
  assign accept = div_v_i && !pend_v_reg;

  // Half-period counter, phase toggle and boundary-gated ratio/enable updates.
  always_comb begin
    cnt_next    = cnt_reg + div_width_p'(1);
    phase_next  = phase_reg;
    div_next    = div_reg;
    en_next     = en_reg;
    pend_v_next = pend_v_reg;
    pend_next   = pend_reg;
    tick_next   = rise_b;

    if (at_end) begin
      cnt_next   = '0;
      phase_next = !phase_reg;
    end

    // A pending ratio takes over at a rising edge so it governs a whole period.
    if (rise_b) begin
      en_next = en_i;
      if (pend_v_reg) begin
        div_next    = pend_reg;
        pend_v_next = 1'b0;
      end
    end

    // Accept only when empty; an accepted value waits for the next rising edge.
    if (accept) begin
      pend_next   = div_i;
      pend_v_next = 1'b1;
    end
  end

  // Each lane is the next divided-clock level gated by the lane's next latched enable.
  genvar gi;
  generate
    for (gi = 0; gi < width_p; gi++) begin : g_lane
      assign o_next[gi] = phase_next & en_next[gi];
    end
  endgenerate

  // State register; reset forces all lanes low immediately and drops pending config.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      div_reg    <= init_div_lp;
      cnt_reg    <= '0;
      phase_reg  <= 1'b0;
      pend_v_reg <= 1'b0;
      pend_reg   <= '0;
      en_reg     <= '0;
      o_reg      <= '0;
      tick_reg   <= 1'b0;
    end else begin
      div_reg    <= div_next;
      cnt_reg    <= cnt_next;
      phase_reg  <= phase_next;
      pend_v_reg <= pend_v_next;
      pend_reg   <= pend_next;
      en_reg     <= en_next;
      o_reg      <= o_next;
      tick_reg   <= tick_next;
    end
  end

  assign o           = o_reg;
  assign tick_o      = tick_reg;
  assign div_ready_o = !pend_v_reg;

endmodule

// File: doc/bsg_clk_div_lanes.md
# bsg_clk_div_lanes

Programmable clock divider with per-lane glitch-free gating. It produces a `width_p`-wide bus of registered divided clocks. That bus feeds the downstream clock-buffer stage lane-for-lane.
- The divide ratio is reconfigured through a valid/ready handshake.
- Ratio changes and lane enable/disable take effect only at a divided-clock rising boundary, so no lane ever emits a runt pulse.

## Interface
- `width_p`, 128, number of output clock lanes.
- `div_width_p`, 8, width of the half-period register.
- `init_div_p`, 0, half-period value loaded at reset.
- `clk_i`  in  1  source clock; all state updates on its rising edge.
- `reset_n_i`  in  1  reset; one clock; reset is asynchronous and active-low.
- `div_v_i`  in  1  new half-period value valid.
- `div_i`  in  `div_width_p`  new half-period value h. Divided period is 2*(h+1) `clk_i` cycles.
- `div_ready_o`  out  1  block can accept `div_i`.
- `en_i`  in  `width_p`  per-lane enable request.
- `o`  out  `width_p`  registered divided clock per lane, to the clock-buffer stage.
- `tick_o`  out  1  high for the first `clk_i` cycle of each divided-clock high phase.

## Operation
- State:
  - `div_r` (current h)
  - `cnt` (0..`div_r`)
  - `phase` (divided clock level)
  - `pend_v`/`pend_r` (accepted, not yet applied h)
  - `en_r[width_p]` (latched enables)
- Counter: each cycle, if `cnt`==`div_r` then `cnt`←0 and `phase` toggles; else `cnt`←`cnt`+1. `cnt` compares are unsigned, full `div_width_p` width.
- Rising boundary: the cycle with `cnt`==`div_r` and `phase`==0. In that cycle:
  - `en_r`←`en_i`.
  - If `pend_v`, then `div_r`←`pend_r` and `pend_v`←0. The new h governs the high phase that starts now.
- Falling boundary (`cnt`==`div_r`, `phase`==1): no enable or ratio update.
- `o[k]` is registered as next-`phase` AND next-`en_r[k]`:
  - A lane disabled mid-high-phase finishes its full high pulse.
  - A lane enabled mid-period first rises at the next rising boundary.
- `tick_o` is registered and equals 1 exactly in the cycle after a rising boundary, regardless of enables.
- Config handshake:
  - `div_ready_o` = !`pend_v`.
  - On `div_v_i` && `div_ready_o`: `pend_r`←`div_i`, `pend_v`←1.
  - A value accepted in a rising-boundary cycle is not applied in that cycle. It is applied at the following rising boundary.
  - `div_v_i` while not ready is ignored; no queueing beyond one entry.
- h=0 gives divide-by-2. h=2^`div_width_p`-1 gives the maximum period, 2^(`div_width_p`+1) cycles.

## Timing
- Reset (async assert, immediate):
  - `o`=0, `tick_o`=0, `div_ready_o`=1.
  - `cnt`=0, `phase`=0, `div_r`=`init_div_p`, `pend_v`=0, `en_r`=0.
- Reset deassertion is assumed synchronized externally. First edge after release = E1.
- With h=0 and `en_i` all ones:
  - `o` rises after E1 and falls after E2; period 2.
  - `tick_o` is high after E1, E3, E5, ….
- With h=2: `o` rises after E3, falls after E6, rises after E9.
- Latency from handshake to effect: minimum 1 cycle, maximum 2*(old h+1) cycles (the next rising boundary).
- `div_ready_o` returns to 1 the cycle after the apply boundary.
- Reset asserted mid-operation: pending config discarded, all lanes low at once, the divider restarts from the E1 rules.

## Test plan
- Reset, `init_div_p`=0, `en_i`=all ones -> every `o[k]` toggles each cycle starting after E1; `tick_o` high on odd edges.
- h=0, then handshake `div_i`=3 in a falling-boundary cycle:
  - `div_ready_o` goes 0 for 1 cycle.
  - The next high phase lasts 4 cycles, low 4; period 8 thereafter.
- h=2, deassert `en_i[5]` one cycle into a high phase:
  - `o[5]` completes its 3-cycle high pulse, then stays 0.
  - Re-assert mid-low: `o[5]` rises exactly at the next rising boundary, aligned with `o[0]`.
- Handshake accepted in the same cycle as a rising boundary, `div_i`=1 while h=2 -> the current period stays 6 cycles; the next period is 4.
- Second `div_v_i` while `pend_v`=1 -> `div_ready_o`=0, value ignored, first value applied.
- Assert `reset_n_i`=0 mid high phase with a pending update -> `o`=0 and `tick_o`=0 immediately, `div_ready_o`=1. After release, behaves per `init_div_p`.
